dmem_arbiter: RTL and testbench
===============================

# dmem_arbiter

Two-requester arbiter that shares the single `data_memory` instance between the CPU's MEM-stage port and a debug/loader port. The CPU has priority, but a wait counter guarantees forward progress for the debug port, and locked debug bursts are bounded. It sits between `cpu` and `data_memory` in the top level and in the instruction testbenches. While the debug port owns the memory it stalls the pipeline through `cpu_stall`.

## Interface
- `MAX_WAIT`, default 4: cycles a debug request may be refused before it preempts the CPU; must be ≥ 1.
- `MAX_BURST`, default 8: maximum accepted beats in one locked debug burst; must be ≥ 1.
- `clk` in 1: single clock; all state updates on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `cpu_req` in 1: CPU MEM stage performs a load or store this cycle.
- `cpu_wr_en` in 1: CPU store.
- `cpu_mem_op` in `mem_op_t`: CPU access size and sign (from `control_types_pkg`).
- `cpu_addr`, `cpu_wdata` in 32: CPU address and store data.
- `cpu_rdata` out 32: load data returned to the CPU.
- `cpu_stall` out 1: CPU access refused this cycle; the pipeline must hold.
- `dbg_req` in 1: debug access valid.
- `dbg_wr_en` in 1: debug write.
- `dbg_lock` in 1: request to keep ownership across consecutive beats.
- `dbg_mem_op` in `mem_op_t`: debug access size and sign.
- `dbg_addr`, `dbg_wdata` in 32: debug address and write data.
- `dbg_gnt` out 1: debug beat accepted when `dbg_req && dbg_gnt` at the clock edge.
- `dbg_rvalid` out 1: registered read data valid.
- `dbg_rdata` out 32: registered read data.
- `mem_wr_en` out 1: to `data_memory` `wr_en`.
- `mem_op` out `mem_op_t`: to `data_memory` `mem_ctrl`.
- `mem_addr`, `mem_data_in` out 32: to `data_memory`.
- `mem_data_out` in 32: combinational read data from `data_memory`.

## Operation
- **States:**
  - `CPU_OWN`: the reset state.
  - `DBG_OWN`: a locked debug burst is in progress.
- **`dbg_gnt`** is combinational:
  - in `DBG_OWN`: 1;
  - in `CPU_OWN`: `!cpu_req || (wait_cnt == MAX_WAIT)`.
- **Debug accepted:** `dbg_acc = dbg_req && dbg_gnt`.
- **Memory mux:**
  - If `dbg_acc`, the debug fields drive `mem_*`.
  - Otherwise the CPU fields drive `mem_*`.
  - `mem_wr_en = dbg_acc ? dbg_wr_en : (cpu_req && cpu_wr_en && !cpu_stall)`.
  - No write ever reaches memory from a refused requester.
- **`cpu_stall`** is combinational:
  - in `DBG_OWN`: `cpu_req`;
  - in `CPU_OWN`: `cpu_req && dbg_acc`.
- **`cpu_rdata`:** `mem_data_out` when the CPU owns the port, else 0.
- **`wait_cnt`** (saturates at `MAX_WAIT`):
  - cleared on `dbg_acc` or `!dbg_req`;
  - otherwise incremented.
- **`burst_cnt`:**
  - counts accepted beats in `DBG_OWN`;
  - loaded with 1 on `CPU_OWN`→`DBG_OWN`;
  - cleared on return to `CPU_OWN`.
- **Transitions:**
  - `CPU_OWN`→`DBG_OWN` when `dbg_acc && dbg_lock`.
  - `DBG_OWN`→`CPU_OWN` when any of these holds:
    - `!dbg_req`;
    - `!dbg_lock`;
    - `dbg_acc` with `burst_cnt == MAX_BURST - 1` (the beat that makes the count `MAX_BURST`).
  - `MAX_BURST` = 1 means the state never enters `DBG_OWN`.
- **Fairness after a burst:** after leaving `DBG_OWN`, `wait_cnt` restarts at 0, so a pending CPU request wins the next cycle.
- **Reads:** on `dbg_acc && !dbg_wr_en`, `dbg_rdata` <= `mem_data_out` and `dbg_rvalid` <= 1 next cycle; otherwise `dbg_rvalid` <= 0 and `dbg_rdata` holds.

## Timing
- **Reset (async, immediate):**
  - state `CPU_OWN`;
  - `wait_cnt` 0, `burst_cnt` 0;
  - `dbg_rvalid` 0, `dbg_rdata` 0.
- **Combinational outputs during reset:** `dbg_gnt`, `cpu_stall` and `mem_*` follow their equations with state `CPU_OWN` and `wait_cnt` 0.
- **Reset mid-burst:** abandons the burst with no further writes; the next post-reset cycle behaves as a fresh `CPU_OWN`.
- **Latency:**
  - CPU access: 0 cycles, write at the same edge.
  - Debug write: at the edge where `dbg_acc` is true.
  - Debug read: `dbg_rvalid` one cycle after acceptance, 1 cycle wide per beat; back-to-back reads give a continuous `dbg_rvalid`.
- **Worst-case debug wait:** `MAX_WAIT` refused cycles; accepted on cycle `MAX_WAIT + 1` of continuous `cpu_req`.
- **Worst-case CPU stall:** `MAX_BURST` cycles per locked burst.
- **Debug master rule:** must hold `dbg_*` stable while `dbg_req && !dbg_gnt`.
- **CPU rule:** holds its request while `cpu_stall`.

## Test plan
- **CPU only.** `cpu_req` store word `0xDEADBEEF` @`0x40`, then load @`0x40`, no debug. Required: no stall; `cpu_rdata` = `0xDEADBEEF`; `dbg_gnt` = 0 during `cpu_req`.
- **Idle CPU.** Debug write `0x12345678` @`0x80`, then debug read @`0x80`. Required: `dbg_gnt` = 1 immediately; `dbg_rvalid` = 1 one cycle after the read with `dbg_rdata` = `0x12345678`.
- **Starvation guard.** `cpu_req` continuous, `dbg_req` held from cycle 0, `MAX_WAIT` = 4. Required: `dbg_gnt` 0 for cycles 0–3, 1 in cycle 4; `cpu_stall` = 1 in cycle 4 only; the CPU write of that cycle does not reach memory.
- **Bounded burst.** `dbg_lock` = 1, 10 write beats to `0x100`–`0x124`, `MAX_BURST` = 8, `cpu_req` continuous. Required: 8 beats accepted; `cpu_stall` for 8 cycles; the next cycle goes to the CPU; the remaining 2 beats wait as in the starvation-guard case.
- **Lock dropped early.** Lock dropped after beat 3. Required: return to `CPU_OWN` the same cycle; `burst_cnt` cleared.
- **Reset mid-burst.** `resetn` low during beat 5 of a write burst. Required: no further writes; `dbg_rvalid` 0; state `CPU_OWN`; a CPU load right after reset completes unstalled.

Source files
------------

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
//
// Shares one data_memory port between the CPU MEM stage and a debug/loader
// master. The CPU normally wins. A debug request that has been refused for
// MAX_WAIT cycles preempts the CPU for one beat. A debug beat carrying dbg_lock
// may open a locked burst, which holds the memory for at most MAX_BURST
// accepted beats. While the debug side owns the port, the CPU is told to hold
// through cpu_stall.
//
// Ports
//   clk, resetn                     clock, asynchronous active-low reset
//   cpu_req/cpu_wr_en/cpu_mem_op    CPU access request, store flag, size/sign
//   cpu_addr/cpu_wdata              CPU address and store data
//   cpu_rdata                       load data to the CPU (0 when refused)
//   cpu_stall                       CPU access refused this cycle
//   dbg_req/dbg_wr_en/dbg_lock      debug request, write flag, burst lock
//   dbg_mem_op/dbg_addr/dbg_wdata   debug size/sign, address, write data
//   dbg_gnt                         debug beat accepted when dbg_req && dbg_gnt
//   dbg_rvalid/dbg_rdata            registered debug read data
//   mem_wr_en/mem_op/mem_addr/
//   mem_data_in/mem_data_out        data_memory port
// -----------------------------------------------------------------------------
package control_types_pkg;
    typedef enum logic [2:0] {
        MEM_B  = 3'd0,
        MEM_H  = 3'd1,
        MEM_W  = 3'd2,
        MEM_BU = 3'd3,
        MEM_HU = 3'd4
    } mem_op_t;
endpackage

module dmem_arbiter
    import control_types_pkg::*;
#(
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        cpu_req,
    input  logic        cpu_wr_en,
    input  mem_op_t     cpu_mem_op,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic [31:0] cpu_rdata,
    output logic        cpu_stall,
    input  logic        dbg_req,
    input  logic        dbg_wr_en,
    input  logic        dbg_lock,
    input  mem_op_t     dbg_mem_op,
    input  logic [31:0] dbg_addr,
    input  logic [31:0] dbg_wdata,
    output logic        dbg_gnt,
    output logic        dbg_rvalid,
    output logic [31:0] dbg_rdata,
    output logic        mem_wr_en,
    output mem_op_t     mem_op,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_data_in,
    input  logic [31:0] mem_data_out
);

    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int BURST_W = $clog2(MAX_BURST + 1);
    localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam logic [BURST_W-1:0] BURST_LAST = BURST_W'(MAX_BURST - 1);
    // A single-beat burst limit makes locking pointless: never leave CPU_OWN.
    localparam bit BURST_ENABLE = (MAX_BURST > 1);

    typedef enum logic {
        CPU_OWN = 1'b0,
        DBG_OWN = 1'b1
    } state_t;

    state_t               state_reg, state_next;
    logic [WAIT_W-1:0]    wait_cnt_reg, wait_cnt_next;
    logic [BURST_W-1:0]   burst_cnt_reg, burst_cnt_next;
    logic                 dbg_rvalid_reg;
    logic [31:0]          dbg_rdata_reg;
    logic                 dbg_acc;
    logic                 in_burst;

    assign in_burst = (state_reg == DBG_OWN);

    // Grant / stall decision. Inside a locked burst the debug side is always
    // granted; otherwise it only gets in when the CPU is idle or the debug
    // request has been starved long enough.
    always_comb begin
        dbg_gnt   = in_burst || !cpu_req || (wait_cnt_reg == WAIT_LIMIT);
        dbg_acc   = dbg_req && dbg_gnt;
        cpu_stall = cpu_req && (in_burst || dbg_acc);
    end

    // Memory port mux. A refused CPU store is masked so it never lands.
    always_comb begin
        if (dbg_acc) begin
            mem_wr_en   = dbg_wr_en;
            mem_op      = dbg_mem_op;
            mem_addr    = dbg_addr;
            mem_data_in = dbg_wdata;
        end else begin
            mem_wr_en   = cpu_req && cpu_wr_en && !cpu_stall;
            mem_op      = cpu_mem_op;
            mem_addr    = cpu_addr;
            mem_data_in = cpu_wdata;
        end
        cpu_rdata = (dbg_acc || cpu_stall) ? 32'd0 : mem_data_out;
    end

    // Next-state logic for ownership, starvation counter and burst length.
    always_comb begin
        state_next     = state_reg;
        burst_cnt_next = burst_cnt_reg;
        wait_cnt_next  = wait_cnt_reg;

        // Any acceptance or an idle debug side restarts the starvation count,
        // so after a burst a waiting CPU access wins the following cycle.
        if (dbg_acc || !dbg_req) begin
            wait_cnt_next = '0;
        end else if (wait_cnt_reg != WAIT_LIMIT) begin
            wait_cnt_next = wait_cnt_reg + 1'b1;
        end

        case (state_reg)
            CPU_OWN: begin
                if (BURST_ENABLE && dbg_acc && dbg_lock) begin
                    state_next     = DBG_OWN;
                    burst_cnt_next = BURST_W'(1);
                end
            end
            DBG_OWN: begin
                // The beat that brings the count to MAX_BURST is still
                // accepted, but ownership returns to the CPU at that edge.
                if (!dbg_req || !dbg_lock ||
                    (dbg_acc && (burst_cnt_reg == BURST_LAST))) begin
                    state_next     = CPU_OWN;
                    burst_cnt_next = '0;
                end else if (dbg_acc) begin
                    burst_cnt_next = burst_cnt_reg + 1'b1;
                end
            end
            default: begin
                state_next     = CPU_OWN;
                burst_cnt_next = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= CPU_OWN;
            wait_cnt_reg   <= '0;
            burst_cnt_reg  <= '0;
            dbg_rvalid_reg <= 1'b0;
            dbg_rdata_reg  <= '0;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            burst_cnt_reg <= burst_cnt_next;
            if (dbg_acc && !dbg_wr_en) begin
                dbg_rvalid_reg <= 1'b1;
                dbg_rdata_reg  <= mem_data_out;
            end else begin
                dbg_rvalid_reg <= 1'b0;
            end
        end
    end

    assign dbg_rvalid = dbg_rvalid_reg;
    assign dbg_rdata  = dbg_rdata_reg;

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
//
// Directed bench for dmem_arbiter with a word-wide memory behind the port and
// an arbitration model that is checked against the DUT every cycle. Inputs
// change 1 time unit after the rising edge; everything is sampled on the
// falling edge.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;
    import control_types_pkg::*;

    localparam int MAX_WAIT  = 4;
    localparam int MAX_BURST = 8;

    logic        clk = 1'b0;
    logic        resetn;
    logic        cpu_req, cpu_wr_en;
    mem_op_t     cpu_mem_op;
    logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
    logic        cpu_stall;
    logic        dbg_req, dbg_wr_en, dbg_lock;
    mem_op_t     dbg_mem_op;
    logic [31:0] dbg_addr, dbg_wdata;
    logic        dbg_gnt, dbg_rvalid;
    logic [31:0] dbg_rdata;
    logic        mem_wr_en;
    mem_op_t     mem_op;
    logic [31:0] mem_addr, mem_data_in, mem_data_out;

    int checks = 0;
    int errors = 0;

    logic [31:0] env_mem [256];
    logic [31:0] ref_mem [256];

    always #5 clk = ~clk;

    dmem_arbiter #(.MAX_WAIT(MAX_WAIT), .MAX_BURST(MAX_BURST)) dut (
        .clk(clk), .resetn(resetn),
        .cpu_req(cpu_req), .cpu_wr_en(cpu_wr_en), .cpu_mem_op(cpu_mem_op),
        .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
        .cpu_stall(cpu_stall),
        .dbg_req(dbg_req), .dbg_wr_en(dbg_wr_en), .dbg_lock(dbg_lock),
        .dbg_mem_op(dbg_mem_op), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
        .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
        .mem_wr_en(mem_wr_en), .mem_op(mem_op), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    // Memory behind the arbiter: combinational read, write at the edge.
    assign mem_data_out = env_mem[mem_addr[9:2]];
    always @(posedge clk) begin
        if (mem_wr_en) env_mem[mem_addr[9:2]] <= mem_data_in;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, req);
        end
    endtask

    // ---------------- arbitration model, checked every cycle ----------------
    initial begin : model
        bit          holds;      // debug side owns the memory in a locked burst
        int          refused;    // consecutive refused debug cycles, capped
        int          beats;      // beats taken in the current locked burst
        logic        rv;
        logic [31:0] rd;
        bit          gnt, acc, stall, wr;
        logic [31:0] addr, data, rdword;
        mem_op_t     op;
        for (int i = 0; i < 256; i++) ref_mem[i] = 32'd0;
        holds = 0; refused = 0; beats = 0; rv = 0; rd = 32'd0;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                holds = 0; refused = 0; beats = 0; rv = 0; rd = 32'd0;
            end
            gnt   = holds || !cpu_req || (refused >= MAX_WAIT);
            acc   = dbg_req && gnt;
            stall = cpu_req && (holds || acc);
            wr    = acc ? dbg_wr_en : (cpu_req && cpu_wr_en && !stall);
            addr  = acc ? dbg_addr : cpu_addr;
            data  = acc ? dbg_wdata : cpu_wdata;
            op    = acc ? dbg_mem_op : cpu_mem_op;
            rdword = ref_mem[addr[9:2]];

            check("m_dbg_gnt", 32'(dbg_gnt), 32'(gnt));
            check("m_cpu_stall", 32'(cpu_stall), 32'(stall));
            check("m_mem_wr_en", 32'(mem_wr_en), 32'(wr));
            check("m_mem_addr", mem_addr, addr);
            check("m_mem_data_in", mem_data_in, data);
            check("m_mem_op", 32'(mem_op), 32'(op));
            check("m_dbg_rvalid", 32'(dbg_rvalid), 32'(rv));
            check("m_dbg_rdata", dbg_rdata, rd);
            if (cpu_req && !stall) check("m_cpu_rdata", cpu_rdata, rdword);
            if (acc) check("m_cpu_rdata_gated", cpu_rdata, 32'd0);

            if (resetn) begin
                if (acc && !dbg_wr_en) begin
                    rv = 1; rd = rdword;
                end else begin
                    rv = 0;
                end
                if (acc || !dbg_req) refused = 0;
                else if (refused < MAX_WAIT) refused++;
                if (!holds) begin
                    if (acc && dbg_lock && MAX_BURST > 1) begin
                        holds = 1; beats = 1;
                    end
                end else begin
                    if (acc) beats++;
                    if (!dbg_req || !dbg_lock || beats >= MAX_BURST) begin
                        holds = 0; beats = 0;
                    end
                end
            end
            if (wr) ref_mem[addr[9:2]] = data;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cpu_req = 0; cpu_wr_en = 0; dbg_req = 0; dbg_wr_en = 0; dbg_lock = 0;
    endtask

    initial begin : stim
        int k, n, nstall, nbad;
        int acc_cyc [10];
        logic g8, s8;
        logic [31:0] rd8;

        idle();
        cpu_mem_op = MEM_W; dbg_mem_op = MEM_W;
        cpu_addr = 0; cpu_wdata = 0; dbg_addr = 0; dbg_wdata = 0;
        resetn = 0;
        step();
        @(negedge clk);
        check("rst_rvalid", 32'(dbg_rvalid), 32'd0);
        check("rst_rdata", dbg_rdata, 32'd0);
        check("rst_gnt_idle_cpu", 32'(dbg_gnt), 32'd1);
        check("rst_stall", 32'(cpu_stall), 32'd0);
        step();

        // CPU only: store then load
        resetn = 1;
        cpu_req = 1; cpu_wr_en = 1; cpu_addr = 32'h40; cpu_wdata = 32'hDEADBEEF;
        @(negedge clk);
        $display("cpu store @%h data %h stall %0b", cpu_addr, cpu_wdata, cpu_stall);
        check("t1_st_stall", 32'(cpu_stall), 32'd0);
        check("t1_st_gnt", 32'(dbg_gnt), 32'd0);
        step();
        cpu_wr_en = 0;
        @(negedge clk);
        $display("cpu load  @%h data %h stall %0b", cpu_addr, cpu_rdata, cpu_stall);
        check("t1_ld_rdata", cpu_rdata, 32'hDEADBEEF);
        check("t1_ld_stall", 32'(cpu_stall), 32'd0);
        check("t1_ld_gnt", 32'(dbg_gnt), 32'd0);
        step();
        idle();

        // Idle CPU: debug write then read
        dbg_req = 1; dbg_wr_en = 1; dbg_addr = 32'h80; dbg_wdata = 32'h12345678;
        @(negedge clk);
        $display("dbg write @%h data %h gnt %0b", dbg_addr, dbg_wdata, dbg_gnt);
        check("t2_wr_gnt", 32'(dbg_gnt), 32'd1);
        step();
        dbg_wr_en = 0;
        @(negedge clk);
        $display("dbg read  @%h gnt %0b", dbg_addr, dbg_gnt);
        check("t2_rd_gnt", 32'(dbg_gnt), 32'd1);
        step();
        idle();
        @(negedge clk);
        $display("dbg rdata %h rvalid %0b", dbg_rdata, dbg_rvalid);
        check("t2_rvalid", 32'(dbg_rvalid), 32'd1);
        check("t2_rdata", dbg_rdata, 32'h12345678);
        step();
        @(negedge clk);
        check("t2_rvalid_single", 32'(dbg_rvalid), 32'd0);
        step();

        // Starvation guard: continuous CPU stores, debug write held
        dbg_req = 1; dbg_wr_en = 1; dbg_lock = 0; dbg_addr = 32'h84; dbg_wdata = 32'hCAFEF00D;
        cpu_req = 1; cpu_wr_en = 1;
        n = 0;
        for (int c = 0; c < 6; c++) begin
            if (c == 5) dbg_req = 0;
            cpu_addr = 32'h48 + 32'(n) * 4; cpu_wdata = 32'h1000 + 32'(n);
            @(negedge clk);
            $display("starve cycle %0d gnt %0b stall %0b mem_addr %h", c, dbg_gnt, cpu_stall, mem_addr);
            if (c < 5) begin
                check("t3_gnt", 32'(dbg_gnt), (c == 4) ? 32'd1 : 32'd0);
                check("t3_stall", 32'(cpu_stall), (c == 4) ? 32'd1 : 32'd0);
            end
            if (c == 4) begin
                check("t3_wr_owner_addr", mem_addr, 32'h84);
                check("t3_wr_data", mem_data_in, 32'hCAFEF00D);
            end
            if (c == 5) check("t3_cpu_retry_addr", mem_addr, 32'h58);
            if (!cpu_stall) n++;
            step();
        end
        idle();
        @(negedge clk);
        check("t3_dbg_word", env_mem[8'h21], 32'hCAFEF00D);
        check("t3_cpu_word", env_mem[8'h16], 32'h1004);
        step();

        // Bounded locked write burst against continuous CPU loads
        cpu_req = 1; cpu_wr_en = 0; cpu_addr = 32'h40;
        k = 0; nstall = 0;
        for (int i = 0; i < 10; i++) acc_cyc[i] = -1;
        for (int c = 0; c < 22; c++) begin
            dbg_req = (k < 10); dbg_wr_en = 1; dbg_lock = 1;
            dbg_addr = 32'h100 + 32'(k) * 4; dbg_wdata = 32'hB0000000 + 32'(k);
            @(negedge clk);
            if (c <= 12 && cpu_stall) nstall++;
            if (dbg_req && dbg_gnt && k < 10) begin
                $display("burst beat %0d @%h accepted cycle %0d", k, dbg_addr, c);
                acc_cyc[k] = c; k++;
            end
            step();
        end
        idle();
        check("t4_beats", 32'(k), 32'd10);
        check("t4_first_beat", 32'(acc_cyc[0]), 32'd4);
        check("t4_eighth_beat", 32'(acc_cyc[7]), 32'd11);
        check("t4_ninth_beat", 32'(acc_cyc[8]), 32'd16);
        check("t4_tenth_beat", 32'(acc_cyc[9]), 32'd17);
        check("t4_stall_cycles", 32'(nstall), 32'd8);
        nbad = 0;
        for (int j = 0; j < 10; j++) if (env_mem[64 + j] !== 32'hB0000000 + 32'(j)) nbad++;
        check("t4_burst_words", 32'(nbad), 32'd0);
        step();

        // Lock dropped on the fourth beat of a read burst
        cpu_req = 1; cpu_wr_en = 0; cpu_addr = 32'h40;
        k = 0; g8 = 1'b1; s8 = 1'b1; rd8 = 32'd0;
        for (int i = 0; i < 10; i++) acc_cyc[i] = -1;
        for (int c = 0; c < 16; c++) begin
            dbg_req = (k < 5); dbg_wr_en = 0; dbg_lock = (k < 3);
            dbg_addr = 32'h100 + 32'(k) * 4;
            @(negedge clk);
            if (c == 8) begin g8 = dbg_gnt; s8 = cpu_stall; rd8 = dbg_rdata; end
            if (dbg_req && dbg_gnt && k < 5) begin
                $display("read beat %0d @%h accepted cycle %0d lock %0b", k, dbg_addr, c, dbg_lock);
                acc_cyc[k] = c; k++;
            end
            step();
        end
        idle();
        check("t5_beats", 32'(k), 32'd5);
        check("t5_unlocked_beat", 32'(acc_cyc[3]), 32'd7);
        check("t5_gnt_after_drop", 32'(g8), 32'd0);
        check("t5_stall_after_drop", 32'(s8), 32'd0);
        check("t5_rdata_beat4", rd8, 32'hB0000003);
        check("t5_retry_beat", 32'(acc_cyc[4]), 32'd12);
        step();

        // Reset in the middle of a locked burst, CPU idle
        for (int b = 0; b < 4; b++) begin
            dbg_req = 1; dbg_lock = 1; dbg_wr_en = (b != 3);
            dbg_addr = (b == 3) ? 32'h80 : 32'h200 + 32'(b) * 4;
            dbg_wdata = 32'hC0000000 + 32'(b);
            @(negedge clk);
            $display("reset-test beat %0d @%h gnt %0b", b, dbg_addr, dbg_gnt);
            step();
        end
        resetn = 0; idle();
        @(negedge clk);
        check("t6_rst_rvalid", 32'(dbg_rvalid), 32'd0);
        check("t6_rst_wr", 32'(mem_wr_en), 32'd0);
        step();
        resetn = 1;
        cpu_req = 1; cpu_wr_en = 0; cpu_addr = 32'h40;
        dbg_req = 1; dbg_lock = 1; dbg_wr_en = 1; dbg_addr = 32'h210; dbg_wdata = 32'hC0000004;
        @(negedge clk);
        $display("post-reset cpu load @%h data %h stall %0b", cpu_addr, cpu_rdata, cpu_stall);
        check("t6_cpu_stall", 32'(cpu_stall), 32'd0);
        check("t6_cpu_rdata", cpu_rdata, 32'hDEADBEEF);
        check("t6_dbg_gnt", 32'(dbg_gnt), 32'd0);
        check("t6_no_write", 32'(mem_wr_en), 32'd0);
        step();
        idle();
        step();
        @(negedge clk);
        check("t6_abandoned_word", env_mem[8'h84], 32'd0);
        nbad = 0;
        for (int i = 0; i < 256; i++) if (env_mem[i] !== ref_mem[i]) nbad++;
        check("mem_image", 32'(nbad), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
